decision_ctrl: RTL and testbench

- Sequences DPLL search for the solver by walking the decision memory, one (var_idx, val) per decision index.
- Issues each decision to the assignment/BCP engine and keeps an internal decision trail (stack).
- On a BCP conflict it backtracks chronologically: pops flipped decisions, requests an undo, and re-issues the top unflipped decision with its value inverted.
- Reports SAT when every decision in the list survives BCP, and UNSAT when the trail empties.

---
 rtl/decision_ctrl.sv | 149 ++++++++++++++
 tb/tb_decision_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/decision_ctrl.sv
// decision_ctrl: walks the decision list, issues each decision to the BCP engine and
// backtracks chronologically over an internal trail on conflict.
module decision_ctrl #(
  parameter int NUM_VARS = 64,
  parameter int VAR_BITS = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [VAR_BITS:0]   num_dec,
  output logic                mem_rd_en,
  output logic [VAR_BITS-1:0] mem_addr,
  input  logic [VAR_BITS-1:0] mem_var_idx,
  input  logic                mem_val,
  output logic                asg_valid,
  input  logic                asg_ready,
  output logic [VAR_BITS-1:0] asg_var_idx,
  output logic                asg_val,
  output logic [VAR_BITS:0]   asg_level,
  input  logic                bcp_done,
  input  logic                bcp_conflict,
  output logic                undo_valid,
  output logic [VAR_BITS:0]   undo_level,
  input  logic                undo_ack,
  output logic                busy,
  output logic                sat,
  output logic                unsat
);
  typedef enum logic [3:0] {IDLE, FETCH, LATCH, ISSUE, WAIT_BCP, BACKTRACK, UNDO, FLIP, SAT, UNSAT} state_t;
  state_t state_q, state_d;
  logic [VAR_BITS-1:0] dec_ptr_q, dec_ptr_d, asg_var_idx_q, asg_var_idx_d, top;
  logic [VAR_BITS:0] sp_q, sp_d, num_q, num_d, asg_level_q, asg_level_d, undo_level_q, undo_level_d;
  logic asg_val_q, asg_val_d, mem_rd_en_q, asg_valid_q, undo_valid_q, busy_q, sat_q, unsat_q;
  logic [VAR_BITS-1:0] tr_var [NUM_VARS];
  logic tr_val [NUM_VARS];
  logic tr_flip [NUM_VARS];
  assign top = sp_q[VAR_BITS-1:0] - 1'b1;
  assign mem_addr = dec_ptr_q;
  assign mem_rd_en = mem_rd_en_q;
  assign asg_valid = asg_valid_q;
  assign asg_var_idx = asg_var_idx_q;
  assign asg_val = asg_val_q;
  assign asg_level = asg_level_q;
  assign undo_valid = undo_valid_q;
  assign undo_level = undo_level_q;
  assign busy = busy_q;
  assign sat = sat_q;
  assign unsat = unsat_q;
  always_comb begin
    state_d = state_q;
    dec_ptr_d = dec_ptr_q;
    sp_d = sp_q;
    num_d = num_q;
    asg_var_idx_d = asg_var_idx_q;
    asg_val_d = asg_val_q;
    asg_level_d = asg_level_q;
    undo_level_d = undo_level_q;
    unique case (state_q)
      IDLE, SAT, UNSAT:
        if (start) begin
          num_d = num_dec;
          sp_d = '0;
          dec_ptr_d = '0;
          state_d = (num_dec == '0) ? SAT : FETCH;
        end
      FETCH: state_d = LATCH;
      LATCH: begin
        sp_d = sp_q + 1'b1;
        asg_var_idx_d = mem_var_idx;
        asg_val_d = mem_val;
        asg_level_d = sp_q + 1'b1;
        state_d = ISSUE;
      end
      ISSUE: state_d = asg_ready ? WAIT_BCP : ISSUE;
      WAIT_BCP:
        if (bcp_done) begin
          if (bcp_conflict) state_d = BACKTRACK;
          else if ({1'b0, dec_ptr_q} + 1'b1 == num_q) state_d = SAT;
          else begin
            dec_ptr_d = dec_ptr_q + 1'b1;
            state_d = FETCH;
          end
        end
      // Flipped entries have exhausted both polarities and are discarded.
      BACKTRACK:
        if (sp_q == '0) state_d = UNSAT;
        else if (tr_flip[top]) begin
          sp_d = sp_q - 1'b1;
          dec_ptr_d = dec_ptr_q - 1'b1;
        end else begin
          undo_level_d = sp_q;
          state_d = UNDO;
        end
      UNDO: state_d = undo_ack ? FLIP : UNDO;
      FLIP: begin
        asg_var_idx_d = tr_var[top];
        asg_val_d = ~tr_val[top];
        asg_level_d = sp_q;
        state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dec_ptr_q <= '0;
      sp_q <= '0;
      num_q <= '0;
      asg_var_idx_q <= '0;
      asg_val_q <= 1'b0;
      asg_level_q <= '0;
      undo_level_q <= '0;
      mem_rd_en_q <= 1'b0;
      asg_valid_q <= 1'b0;
      undo_valid_q <= 1'b0;
      busy_q <= 1'b0;
      sat_q <= 1'b0;
      unsat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_ptr_q <= dec_ptr_d;
      sp_q <= sp_d;
      num_q <= num_d;
      asg_var_idx_q <= asg_var_idx_d;
      asg_val_q <= asg_val_d;
      asg_level_q <= asg_level_d;
      undo_level_q <= undo_level_d;
      mem_rd_en_q <= state_d == FETCH;
      asg_valid_q <= state_d == ISSUE;
      undo_valid_q <= state_d == UNDO;
      busy_q <= !(state_d inside {IDLE, SAT, UNSAT});
      sat_q <= state_d == SAT;
      unsat_q <= state_d == UNSAT;
    end
  end
  // Trail storage needs no reset: sp bounds every valid entry.
  always_ff @(posedge clock) begin
    if (state_q == LATCH) begin
      tr_var[sp_q[VAR_BITS-1:0]] <= mem_var_idx;
      tr_val[sp_q[VAR_BITS-1:0]] <= mem_val;
      tr_flip[sp_q[VAR_BITS-1:0]] <= 1'b0;
    end
    if (state_q == FLIP) begin
      tr_val[top] <= ~tr_val[top];
      tr_flip[top] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_decision_ctrl.sv
// tb_decision_ctrl: scoreboard bench; a DPLL reference model predicts the ordered
// fetch/assign/undo/result events, a monitor pops and compares them as the DUT shows them.
module tb_decision_ctrl;
  localparam int VB = 6;
  localparam int NV = 64;
  logic clock = 0, reset = 0, start = 0;
  logic [VB:0] num_dec = '0;
  logic mem_rd_en, asg_valid, asg_val, undo_valid, busy, sat, unsat;
  logic [VB-1:0] mem_addr, asg_var_idx;
  logic [VB:0] asg_level, undo_level;
  logic [VB-1:0] mem_var_idx = '0;
  logic mem_val = 0, asg_ready = 0, bcp_done = 0, bcp_conflict = 0, undo_ack = 0;

  decision_ctrl #(.NUM_VARS(NV), .VAR_BITS(VB)) dut (
    .clock(clock), .reset(reset), .start(start), .num_dec(num_dec),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_var_idx(mem_var_idx), .mem_val(mem_val),
    .asg_valid(asg_valid), .asg_ready(asg_ready), .asg_var_idx(asg_var_idx), .asg_val(asg_val),
    .asg_level(asg_level), .bcp_done(bcp_done), .bcp_conflict(bcp_conflict),
    .undo_valid(undo_valid), .undo_level(undo_level), .undo_ack(undo_ack),
    .busy(busy), .sat(sat), .unsat(unsat));

  always #5 clock = ~clock;

  typedef struct {int kind; int a; int b; int c;} ev_t;
  ev_t exp_q[$];
  int checks = 0, errors = 0;
  logic [VB-1:0] mvar [NV];
  bit mv [NV];
  bit ct [NV][2];
  int rmode = 0, udelay = 0, bdelay = 1;
  bit noise = 0;

  task automatic chk(string name, longint act, longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic void push(int k, int a, int b, int c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endfunction

  // Event kinds: 0 fetch(addr), 1 assign(var,val,level), 2 undo(level), 3 sat, 4 unsat.
  function automatic void model(int n);
    int k, v;
    bit fl [NV];
    if (n == 0) begin push(3, 0, 0, 0); return; end
    k = 0; fl[0] = 0;
    push(0, 0, 0, 0);
    while (1) begin
      v = mv[k] ^ fl[k];
      push(1, mvar[k], v, k + 1);
      if (!ct[k][v]) begin
        if (k + 1 == n) begin push(3, 0, 0, 0); return; end
        k++; fl[k] = 0;
        push(0, k, 0, 0);
      end else begin
        while (k >= 0 && fl[k]) k--;
        if (k < 0) begin push(4, 0, 0, 0); return; end
        push(2, k + 1, 0, 0);
        fl[k] = 1;
      end
    end
  endfunction

  task automatic got(int k, int a, int b, int c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind=%0d a=%0d b=%0d c=%0d, expected no event", k, a, b, c);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.a != a || e.b != b || e.c != c) begin
      errors++;
      $display("FAIL event: got kind=%0d a=%0d b=%0d c=%0d expected kind=%0d a=%0d b=%0d c=%0d",
               k, a, b, c, e.kind, e.a, e.b, e.c);
    end
  endtask

  // Environment: decision memory, BCP engine and undo responder.
  initial begin
    int bcnt = 0, wcnt = 0, ucnt = 0, ucur = 0, blvl = 1, ra = 0;
    bit bval = 0, rd_prev = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        bcnt = 0; wcnt = 0; ucnt = 0; rd_prev = 0;
        asg_ready = 0; undo_ack = 0; bcp_done = 0;
        continue;
      end
      if (rd_prev) begin mem_var_idx = mvar[ra]; mem_val = mv[ra]; end
      else begin mem_var_idx = VB'($urandom); mem_val = 1'($urandom); end
      rd_prev = mem_rd_en; ra = int'(mem_addr);
      bcp_done = 0; bcp_conflict = 1'($urandom);
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin bcp_done = 1; bcp_conflict = ct[blvl-1][bval]; end
      end else if (noise && $urandom_range(7) == 0) bcp_done = 1;
      if (asg_valid) begin
        asg_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? (wcnt >= 4) : 1'($urandom_range(1));
        wcnt++;
      end else begin
        wcnt = 0;
        asg_ready = noise ? 1'($urandom) : 1'b0;
      end
      if (asg_valid && asg_ready) begin
        bcnt = (bdelay > 0) ? bdelay : $urandom_range(1, 3);
        blvl = int'(asg_level); bval = asg_val;
      end
      if (undo_valid) begin
        if (ucnt == 0) ucur = (udelay >= 0) ? udelay : $urandom_range(3);
        undo_ack = (ucnt >= ucur);
        ucnt++;
      end else begin
        ucnt = 0;
        undo_ack = noise && ($urandom_range(7) == 0);
      end
    end
  end

  // Monitor: compares every observed event against the scoreboard.
  initial begin
    bit psat = 0, punsat = 0, pav = 0, pud = 0, prdy = 0, pack = 0;
    longint pasg = 0, pundo = 0;
    int age = 99;
    forever begin
      @(negedge clock); #1;
      if (!reset) begin psat = 0; punsat = 0; pav = 0; pud = 0; age = 99; continue; end
      if (pav && !prdy) chk("asg_hold", {asg_valid, asg_var_idx, asg_val, asg_level}, pasg);
      if (pud && !pack) chk("undo_hold", {undo_valid, undo_level}, pundo);
      if (age < 99) age++;
      if (age == 1) chk("rd_single_cycle", mem_rd_en, 0);
      if (age == 2) chk("fetch_to_valid", asg_valid, 1);
      if (mem_rd_en) begin got(0, int'(mem_addr), 0, 0); age = 0; end
      if (asg_valid && asg_ready) got(1, int'(asg_var_idx), int'(asg_val), int'(asg_level));
      if (undo_valid && undo_ack) got(2, int'(undo_level), 0, 0);
      if (sat && !psat) got(3, 0, 0, 0);
      if (unsat && !punsat) got(4, 0, 0, 0);
      psat = sat; punsat = unsat; pav = asg_valid; prdy = asg_ready; pud = undo_valid; pack = undo_ack;
      pasg = {asg_valid, asg_var_idx, asg_val, asg_level};
      pundo = {undo_valid, undo_level};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    foreach (mvar[i]) begin mvar[i] = '0; mv[i] = 0; ct[i][0] = 0; ct[i][1] = 0; end
  endtask

  task automatic run(int n, bit spur);
    int cyc = 0;
    model(n);
    @(negedge clock); start = 1; num_dec = (VB+1)'(n);
    @(negedge clock); start = 0; num_dec = (VB+1)'($urandom);
    #1 chk("start_flags", {busy, sat, unsat}, (n == 0) ? 3'b010 : 3'b100);
    if (spur && n > 0) begin
      @(negedge clock); start = 1; num_dec = (VB+1)'($urandom_range(1, 64));
      @(negedge clock); start = 0;
    end
    while (!(sat || unsat) && cyc < 20000) begin @(negedge clock); cyc++; end
    chk("done_within_budget", cyc < 20000, 1);
    repeat (4) @(negedge clock);
    #2 chk("drained", exp_q.size(), 0);
    chk("idle_flags", {busy, sat ^ unsat}, 2'b01);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    clear_mem();
    repeat (3) @(negedge clock);
    #1 chk("reset_outputs", {mem_rd_en, mem_addr, asg_valid, asg_var_idx, asg_val, asg_level,
                             undo_valid, undo_level, busy, sat, unsat}, 0);
    @(negedge clock); reset = 1;
    // Three clean decisions.
    mvar[0] = 5; mv[0] = 1; mvar[1] = 2; mv[1] = 0; mvar[2] = 7; mv[2] = 1;
    run(3, 0);
    // Conflict on the first decision, flipped value succeeds.
    clear_mem(); mvar[0] = 5; mv[0] = 1; mvar[1] = 3; mv[1] = 0; ct[0][1] = 1;
    run(2, 0);
    // Both polarities conflict at level 1.
    clear_mem(); mvar[0] = 4; ct[0][0] = 1; ct[0][1] = 1;
    run(1, 0);
    // Deep trail with flipped entries popped before flipping level 1.
    clear_mem(); mvar[0] = 1; mv[0] = 1; mvar[1] = 2; mvar[2] = 3; mv[2] = 1;
    ct[1][0] = 1; ct[2][0] = 1; ct[2][1] = 1;
    run(3, 0);
    // Slow ready and slow undo acknowledge.
    clear_mem(); mvar[0] = 9; mv[0] = 1; mvar[1] = 11; ct[0][1] = 1;
    rmode = 2; udelay = 3;
    run(2, 0);
    // Reset while waiting on BCP, then an empty search.
    clear_mem(); mvar[0] = 6; mvar[1] = 8; mvar[2] = 10;
    rmode = 0; udelay = 0; bdelay = 6;
    model(3);
    @(negedge clock); start = 1; num_dec = 3;
    @(negedge clock); start = 0;
    cyc = 0;
    while (!(asg_valid && asg_ready) && cyc < 50) begin @(negedge clock); cyc++; end
    chk("reach_wait_bcp", cyc < 50, 1);
    @(negedge clock); #3 reset = 0;
    #1 chk("async_reset", {mem_rd_en, mem_addr, asg_valid, asg_var_idx, asg_val, asg_level,
                           undo_valid, undo_level, busy, sat, unsat}, 0);
    exp_q.delete();
    repeat (2) @(negedge clock); reset = 1;
    bdelay = 1;
    run(0, 0);
    // Randomised searches.
    rmode = 1; udelay = -1; bdelay = 0; noise = 1;
    for (int r = 0; r < 30; r++) begin
      int n;
      n = (r == 29) ? 64 : $urandom_range(1, 6);
      foreach (mvar[i]) begin
        mvar[i] = VB'($urandom); mv[i] = 1'($urandom);
        if (n == 64) begin
          ct[i][0] = 0; ct[i][1] = 0;
          ct[i][$urandom_range(1)] = ($urandom_range(9) == 0);
        end else begin
          ct[i][0] = ($urandom_range(2) == 0);
          ct[i][1] = ($urandom_range(2) == 0);
        end
      end
      run(n, r % 3 == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
